// File: rtl/reg_bank_arbiter.sv
// Round-robin shared register bank: NREQ writers, 2-cycle req/grant/ack write transactions, async read port.
// Define ARB_FIXED_PRIO_EN to replace round-robin with lowest-index-wins fixed priority.
module reg_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [NREQ-1:0]       Req,
  input  logic [NREQ*AW-1:0]    Addr,
  input  logic [NREQ*WIDTH-1:0] Wdata,
  output logic [NREQ-1:0]       Grant,
  output logic [NREQ-1:0]       Ack,
  output logic                  Busy,
  input  logic [AW-1:0]         RdAddr,
  output logic [WIDTH-1:0]      RdData
);
  localparam int DEPTH = 1 << AW;
  localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                 state_q, state_d;
  logic [NREQ-1:0]        grant_q, grant_d;
  logic [NREQ-1:0]        ack_q, ack_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic [DEPTH-1:0][WIDTH-1:0] bank_q;

  logic                   win_vld;
  logic [IW-1:0]          win_idx;
  logic                   we;
  logic [AW-1:0]          waddr;
  logic [WIDTH-1:0]       wdat;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    // Scan downwards so the lowest set index is the last assignment.
    for (int i = NREQ-1; i >= 0; i--) begin
      if (Req[i]) begin
        win_vld = 1'b1;
        win_idx = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] rr_q, rr_d;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    // Scan offsets high to low so the closest requester at or after rr_q wins.
    for (int k = NREQ-1; k >= 0; k--) begin
      if (Req[(int'(rr_q) + k) % NREQ]) begin
        win_vld = 1'b1;
        win_idx = IW'((int'(rr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (state_q == WRITE)
      rr_d = (gidx_q == IW'(NREQ-1)) ? '0 : gidx_q + 1'b1;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) rr_q <= '0;
    else       rr_q <= rr_d;
  end
`endif

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_vld) state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath control
  always_comb begin
    grant_d = '0;
    ack_d   = '0;
    gidx_d  = gidx_q;
    we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant_d = NREQ'(1) << win_idx;
          gidx_d  = win_idx;
        end
      end
      WRITE: begin
        // A requester that dropped Req before commit abandons its slot.
        if (Req[gidx_q]) begin
          we    = 1'b1;
          ack_d = grant_q;
        end
      end
      default: ;
    endcase
  end

  assign waddr = Addr[gidx_q*AW +: AW];
  assign wdat  = Wdata[gidx_q*WIDTH +: WIDTH];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      grant_q <= '0;
      ack_q   <= '0;
      gidx_q  <= '0;
    end else begin
      grant_q <= grant_d;
      ack_q   <= ack_d;
      gidx_q  <= gidx_d;
    end
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_bank
    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)                        bank_q[e] <= '0;
      else if (we && waddr == AW'(e))   bank_q[e] <= wdat;
    end
  end

  assign Grant  = grant_q;
  assign Ack    = ack_q;
  assign Busy   = (state_q == WRITE);
  assign RdData = bank_q[RdAddr];
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter: table of single writes plus hand sequences, scoreboard checks each Ack.
module tb_reg_bank_arbiter;
  localparam int NREQ = 4, WIDTH = 8, AW = 2;

  logic                  Clock = 1'b0;
  logic                  Reset;
  logic [NREQ-1:0]       Req;
  logic [NREQ*AW-1:0]    Addr;
  logic [NREQ*WIDTH-1:0] Wdata;
  logic [NREQ-1:0]       Grant, Ack;
  logic                  Busy;
  logic [AW-1:0]         RdAddr;
  logic [WIDTH-1:0]      RdData;

  reg_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .AW(AW)) dut (
    .Clock(Clock), .Reset(Reset), .Req(Req), .Addr(Addr), .Wdata(Wdata),
    .Grant(Grant), .Ack(Ack), .Busy(Busy), .RdAddr(RdAddr), .RdData(RdData)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int               idx;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } vec_t;

  vec_t             tbl[5];
  vec_t             sb[$];
  logic [WIDTH-1:0] mdl[1<<AW];
  int               tests = 0, fails = 0, cyc = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic set_req(input int idx, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    Addr[idx*AW +: AW]       = a;
    Wdata[idx*WIDTH +: WIDTH] = d;
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      cyc++;
      if (|Ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Pop one scoreboard entry per Ack; non-holding requesters drop Req once acked.
  task automatic drain(input bit hold);
    bit   ok;
    int   last;
    vec_t e;
    last = -1;
    while (sb.size() > 0) begin
      wait_ack(ok);
      if (!ok) begin
        chk("ack_timeout", 32'd0, 32'd1);
        sb.delete();
        break;
      end
      e = sb.pop_front();
      chk("ack_onehot", 32'(Ack), 32'(1 << e.idx));
      mdl[e.addr] = e.data;
      RdAddr = e.addr;
      #1;
      chk("rdata_commit", 32'(RdData), 32'(mdl[e.addr]));
      if (last >= 0) chk("ack_spacing", 32'(cyc - last), 32'd2);
      last = cyc;
      if (!hold) Req[e.idx] = 1'b0;
    end
    Req = '0;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    foreach (mdl[i]) mdl[i] = '0;
  endtask

  always @(negedge Clock)
    if ((|Grant) && (|Ack)) begin
      fails++;
      $display("FAIL grant_ack_overlap: grant %b ack %b", Grant, Ack);
    end

  initial begin
    tbl[0] = '{1, 2'd2, 8'hA5};
    tbl[1] = '{0, 2'd0, 8'h3C};
    tbl[2] = '{3, 2'd1, 8'hF0};
    tbl[3] = '{2, 2'd3, 8'h7E};
    tbl[4] = '{3, 2'd3, 8'h81};
    foreach (mdl[i]) mdl[i] = '0;

    Reset = 1'b1; Req = '0; Addr = '0; Wdata = '0; RdAddr = '0;
    @(negedge Clock);
    chk("rst_grant", 32'(Grant), 32'd0);
    chk("rst_ack", 32'(Ack), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    for (int a = 0; a < (1 << AW); a++) begin
      RdAddr = AW'(a);
      #1;
      chk("rst_rdata", 32'(RdData), 32'd0);
    end
    Reset = 1'b0;
    @(negedge Clock);

    // Table-driven single writes
    foreach (tbl[i]) begin
      set_req(tbl[i].idx, tbl[i].addr, tbl[i].data);
      Req = NREQ'(1) << tbl[i].idx;
      sb.push_back(tbl[i]);
      @(negedge Clock);
      cyc++;
      chk("tbl_grant", 32'(Grant), 32'(1 << tbl[i].idx));
      chk("tbl_busy", 32'(Busy), 32'd1);
      chk("tbl_ack_lo", 32'(Ack), 32'd0);
      drain(1'b0);
      @(negedge Clock);
      chk("tbl_ack_pulse", 32'(Ack), 32'd0);
      chk("tbl_grant_lo", 32'(Grant), 32'd0);
    end

    // Abandon: requester 0 drops Req in its Grant cycle (rr_ptr is 0 here)
    set_req(0, 2'd2, 8'hEE);
    Req = 4'b0001;
    @(negedge Clock);
    chk("abn_grant", 32'(Grant), 32'b0001);
    Req = 4'b0000;
    @(negedge Clock);
    chk("abn_no_ack", 32'(Ack), 32'd0);
    chk("abn_idle", 32'(Busy), 32'd0);
    RdAddr = 2'd2;
    #1;
    chk("abn_bank", 32'(RdData), 32'(mdl[2]));
    set_req(0, 2'd0, 8'h5A);
    set_req(1, 2'd1, 8'h6B);
    Req = 4'b0011;
    sb.push_back('{1, 2'd1, 8'h6B});
    sb.push_back('{0, 2'd0, 8'h5A});
    @(negedge Clock);
    cyc++;
    chk("abn_next_winner", 32'(Grant), 32'b0010);
    drain(1'b0);

    // Reset in the middle of a WRITE
    set_req(2, 2'd2, 8'h99);
    Req = 4'b0100;
    @(negedge Clock);
    chk("rstw_busy", 32'(Busy), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    chk("rstw_grant", 32'(Grant), 32'd0);
    chk("rstw_ack", 32'(Ack), 32'd0);
    chk("rstw_busy0", 32'(Busy), 32'd0);
    for (int a = 0; a < (1 << AW); a++) begin
      RdAddr = AW'(a);
      #1;
      chk("rstw_rdata", 32'(RdData), 32'd0);
    end
    Req = '0;
    foreach (mdl[i]) mdl[i] = '0;
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    chk("rstw_no_ack", 32'(Ack), 32'd0);

    // Same address from requesters 0 and 2, rr_ptr back at 0
    set_req(0, 2'd3, 8'h11);
    set_req(2, 2'd3, 8'h22);
    Req = 4'b0101;
    sb.push_back('{0, 2'd3, 8'h11});
    sb.push_back('{2, 2'd3, 8'h22});
    drain(1'b0);
    RdAddr = 2'd3;
    #1;
    chk("same_addr_final", 32'(RdData), 32'h22);

    // Arbitration order with requests held continuously
    pulse_reset();
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i), 8'h40 + 8'(i));
    Req = 4'b1001;
    for (int k = 0; k < 4; k++) sb.push_back('{0, 2'd0, 8'h40});
    drain(1'b1);
`else
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i), 8'h40 + 8'(i));
    Req = 4'b1111;
    for (int k = 0; k < 5; k++) sb.push_back('{k % NREQ, AW'(k % NREQ), 8'h40 + 8'(k % NREQ)});
    drain(1'b1);
`endif
    @(negedge Clock);
    @(negedge Clock);
    chk("end_idle", 32'(Busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim exceeded time limit");
    $fatal(1);
  end
endmodule
